finish_arbiter: RTL and testbench
=================================

// Module: finish_arbiter
// PURPOSE
//  Collects task-finish notifications from all cores of a tile and serializes them, one per
//  cycle, onto the finished_task_valid/finished_task_core input of the tile's conflict
//  serializer, which accepts a single finish per cycle. Round-robin fair; per-core pending bit
//  (a core runs at most one task). Sits between the core array and the serializer.
// PARAMETERS
//  NUM_CORES    10  cores per tile, incl. core 0 (OCL)
//  LOG_N_CORES  $clog2(NUM_CORES)  derived; width of core index
// PORTS
//  clk                  in   1            clock (only clock)
//  rst                  in   1            sync reset, active-high
//  core_finish_valid    in   NUM_CORES    core i reports its running task finished
//  core_finish_ready    out  NUM_CORES    = !pending[i]; handshake on valid&ready
//  hold                 in   1            1 = issue no finish this cycle; pending kept
//  finished_task_valid  out  1            registered; one finish to serializer
//  finished_task_core   out  LOG_N_CORES  registered; core of that finish
//  pending_count        out  LOG_N_CORES+1 registered popcount of pending[]
//  all_idle             out  1            pending==0 & !finished_task_valid (termination)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: pending=0, rr_ptr=0, finished_task_valid=0, finished_task_core=0, pending_count=0;
//   core_finish_ready=all 1s and all_idle=1 from the first cycle after reset. Reset mid-operation
//   drops all pending finishes; no output the next cycle.
//  Capture: pending[i] set at edge ending cycle N when core_finish_valid[i]&core_finish_ready[i].
//   Valid without ready: ignored (core holds valid; no protocol violation).
//  Arbitration (cycle N+1, combinational on registered pending, NOT on same-cycle arrivals):
//   grant = lowest pending index >= rr_ptr; else lowest pending index overall; none if
//   pending==0 or hold=1.
//  Issue: at edge ending N+1: finished_task_valid<=grant_valid, finished_task_core<=grant
//   (holds last value when valid=0); pending[grant]<=0;
//   rr_ptr<=(grant==NUM_CORES-1)?0:grant+1. Latency capture->serializer = 2 cycles.
//  core_finish_ready[i] returns to 1 in cycle N+2; earliest repeat capture for same core ends N+2.
//  Set and clear of same pending bit in one cycle impossible (ready=0 while pending).
//  hold=1: no grant, rr_ptr unchanged, captures continue; release resumes at rr_ptr.
//  Full: all NUM_CORES pending -> every ready=0; drains in NUM_CORES cycles with hold=0.
//  pending_count: registered next-state popcount, in [0,NUM_CORES]; +1 per capture, -1 per grant.
//  Throughput: 1 finish/cycle sustained; no core waits more than NUM_CORES-1 grants.
// STRUCTURE
//  core_id_t, NUM_CORES tile constants: shared swarm package (existing). No new typedefs.
//  Sub-module: rr_select (NUM_CORES-bit round-robin picker: two lowbit instances, masked by
//   rr_ptr and unmasked, masked result preferred). Counter, pending regs, output regs in top.
// TESTING
//  1 Reset: rst=1 two cycles, all valid=1 -> ready=all1s, no finished_task_valid until 2 cycles
//    after rst falls; pending_count=0 during reset.
//  2 Single: core 3 valid 1 cycle at N -> finished_task_valid=1, core=3 in cycle N+2 only;
//    ready[3]=0 in N+1, 1 in N+2; pending_count 1 in N+1, 0 in N+2.
//  3 Fairness: cores 0,2,9 valid same cycle, rr_ptr=0 -> issues 0,2,9 in consecutive cycles;
//    then 9 and 0 again -> issues 0 then 9 (rr_ptr wrapped to 0 after 9).
//  4 Hold: 4 pending, hold=1 for 5 cycles -> no output, pending_count=4, ready for those=0;
//    hold release -> 4 finishes in 4 consecutive cycles in rr order.
//  5 Full: all 10 cores valid continuously -> exactly one finish per cycle, each core once per
//    10 cycles, pending_count never >10, all_idle=0 throughout.
//  6 Reset mid-op: 5 pending, rst=1 one cycle -> next cycle pending_count=0,
//    finished_task_valid=0, all_idle=1, no dropped finish reappears.

Source files
------------

// File: rtl/finish_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// finish_arbiter_pkg
//   Tile constants and small helpers shared by the finish arbiter files.
//   NUM_CORES   : cores per tile (core 0 included)
//   LOG_N_CORES : width of a core index
//   core_id_t   : core index type
//   lowbit_idx  : index of the lowest set bit of a core vector (0 if none)
//   popcount    : number of set bits of a core vector
// -----------------------------------------------------------------------------
package finish_arbiter_pkg;

    localparam int NUM_CORES   = 10;
    localparam int LOG_N_CORES = $clog2(NUM_CORES);

    typedef logic [LOG_N_CORES-1:0] core_id_t;

    // Scanning downward leaves the lowest set index as the final assignment.
    function automatic core_id_t lowbit_idx(input logic [NUM_CORES-1:0] vec);
        core_id_t idx;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = core_id_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [LOG_N_CORES:0] popcount(input logic [NUM_CORES-1:0] vec);
        logic [LOG_N_CORES:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cnt = cnt + {{LOG_N_CORES{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/finish_arbiter_if.sv
// -----------------------------------------------------------------------------
// finish_arbiter_if
//   Bundles the core-array handshake and the serializer-side outputs of the
//   finish arbiter.
//   master : core array / serializer side (drives valid and hold)
//   slave  : the arbiter (drives ready, finish outputs, count, idle flag)
//   Signals:
//     core_finish_valid   core i reports its running task finished
//     core_finish_ready   core i may report (no finish pending for it)
//     hold                suppress issuing a finish this cycle
//     finished_task_valid one finish presented to the serializer
//     finished_task_core  core of that finish
//     pending_count       number of pending finishes
//     all_idle            nothing pending and nothing being issued
// -----------------------------------------------------------------------------
interface finish_arbiter_if;
    import finish_arbiter_pkg::*;

    logic [NUM_CORES-1:0]  core_finish_valid;
    logic [NUM_CORES-1:0]  core_finish_ready;
    logic                  hold;
    logic                  finished_task_valid;
    core_id_t              finished_task_core;
    logic [LOG_N_CORES:0]  pending_count;
    logic                  all_idle;

    modport master (
        output core_finish_valid,
        output hold,
        input  core_finish_ready,
        input  finished_task_valid,
        input  finished_task_core,
        input  pending_count,
        input  all_idle
    );

    modport slave (
        input  core_finish_valid,
        input  hold,
        output core_finish_ready,
        output finished_task_valid,
        output finished_task_core,
        output pending_count,
        output all_idle
    );

endinterface

// File: rtl/finish_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// finish_arbiter_rr_select
//   Combinational round-robin picker over NUM_CORES request bits.
//   Ports:
//     i_req   request vector
//     i_ptr   round-robin pointer (first index eligible this round)
//     o_valid at least one request present
//     o_idx   lowest request at or above i_ptr, else lowest request overall
// -----------------------------------------------------------------------------
module finish_arbiter_rr_select
    import finish_arbiter_pkg::*;
(
    input  logic [NUM_CORES-1:0] i_req,
    input  core_id_t             i_ptr,
    output logic                 o_valid,
    output core_id_t             o_idx
);

    logic [NUM_CORES-1:0] w_mask;
    logic [NUM_CORES-1:0] w_masked;
    core_id_t             w_masked_idx;
    core_id_t             w_plain_idx;

    // Thermometer mask keeping only indices at or above the pointer.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_mask
            assign w_mask[gi] = (core_id_t'(gi) >= i_ptr);
        end
    endgenerate

    assign w_masked     = i_req & w_mask;
    assign w_masked_idx = lowbit_idx(w_masked);
    assign w_plain_idx  = lowbit_idx(i_req);

    // Wrap to the unmasked search only when nothing sits at or above the pointer.
    assign o_valid = |i_req;
    assign o_idx   = (|w_masked) ? w_masked_idx : w_plain_idx;

endmodule

// File: rtl/finish_arbiter.sv
// -----------------------------------------------------------------------------
// finish_arbiter
//   Collects task-finish notifications from all cores of a tile and issues
//   them one per cycle, round-robin, to the tile's conflict serializer.
//   Each core has one pending bit; a core is ready only while its bit is clear.
//   Ports:
//     clk    clock
//     rst    synchronous active-high reset
//     io_bus finish_arbiter_if.slave (handshake, hold, finish outputs,
//            pending_count, all_idle)
//   Timing: capture at edge ending cycle N, arbitration on registered pending
//   in N+1, finish visible on the registered outputs in N+2.
// -----------------------------------------------------------------------------
module finish_arbiter
    import finish_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    finish_arbiter_if.slave  io_bus
);

    logic [NUM_CORES-1:0]  r_pending;
    core_id_t              r_rr_ptr;
    logic                  r_finished_valid;
    core_id_t              r_finished_core;
    logic [LOG_N_CORES:0]  r_pending_count;

    logic [NUM_CORES-1:0]  w_capture;
    logic [NUM_CORES-1:0]  w_grant_onehot;
    logic [NUM_CORES-1:0]  w_pending_next;
    logic                  w_pick_valid;
    core_id_t              w_pick_idx;
    logic                  w_grant_valid;

    assign io_bus.core_finish_ready = ~r_pending;
    assign w_capture                = io_bus.core_finish_valid & ~r_pending;

    // Arbitration looks only at registered pending, never at this cycle's arrivals.
    finish_arbiter_rr_select u_rr_select (
        .i_req   (r_pending),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_grant_valid = w_pick_valid & ~io_bus.hold;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_grant
            assign w_grant_onehot[gi] = w_grant_valid && (w_pick_idx == core_id_t'(gi));
        end
    endgenerate

    // A bit cannot be captured and granted together: capture needs it clear,
    // grant needs it set.
    assign w_pending_next = (r_pending | w_capture) & ~w_grant_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending        <= '0;
            r_rr_ptr         <= '0;
            r_finished_valid <= 1'b0;
            r_finished_core  <= '0;
            r_pending_count  <= '0;
        end else begin
            r_pending        <= w_pending_next;
            r_pending_count  <= popcount(w_pending_next);
            r_finished_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_finished_core <= w_pick_idx;
                r_rr_ptr        <= (w_pick_idx == core_id_t'(NUM_CORES - 1)) ? '0
                                                                             : w_pick_idx + 1'b1;
            end
        end
    end

    assign io_bus.finished_task_valid = r_finished_valid;
    assign io_bus.finished_task_core  = r_finished_core;
    assign io_bus.pending_count       = r_pending_count;
    assign io_bus.all_idle            = (r_pending == '0) && !r_finished_valid;

endmodule

// File: tb/tb_finish_arbiter.sv
// -----------------------------------------------------------------------------
// tb_finish_arbiter
//   Directed stimulus drives core finishes; every expected finish (core and
//   the cycle it must appear) is pushed into a scoreboard queue and a
//   separate negedge monitor compares the DUT output against it.
// -----------------------------------------------------------------------------
module tb_finish_arbiter;
    import finish_arbiter_pkg::*;

    typedef struct {
        int core;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    finish_arbiter_if bus ();

    finish_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_finish(input int core, input int at_cyc);
        exp_t e;
        e.core = core;
        e.cyc  = at_cyc;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: sampled at negedge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            check("missing_finish", 0, 1);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check("finish_valid", int'(bus.finished_task_valid), 1);
            check("finish_core", int'(bus.finished_task_core), e.core);
        end else if (bus.finished_task_valid) begin
            check("unexpected_finish", int'(bus.finished_task_core), -1);
        end
    end

    initial begin
        int n;
        int all_ones;
        all_ones = (1 << NUM_CORES) - 1;
        bus.core_finish_valid = '1;
        bus.hold = 1'b0;
        rst = 1'b1;

        // ---- 1: reset with all valids asserted ----
        next_cycle();
        check("rst_count", int'(bus.pending_count), 0);
        check("rst_ready", int'(bus.core_finish_ready), all_ones);
        check("rst_valid", int'(bus.finished_task_valid), 0);
        check("rst_idle", int'(bus.all_idle), 1);
        next_cycle();
        check("rst_count2", int'(bus.pending_count), 0);
        rst = 1'b0;
        n = cyc;
        check("post_rst_ready", int'(bus.core_finish_ready), all_ones);
        check("post_rst_idle", int'(bus.all_idle), 1);
        for (int k = 0; k < NUM_CORES; k++) expect_finish(k, n + 2 + k);
        next_cycle();
        bus.core_finish_valid = '0;
        check("post_rst_valid_n1", int'(bus.finished_task_valid), 0);
        check("post_rst_count_n1", int'(bus.pending_count), NUM_CORES);
        check("post_rst_ready_n1", int'(bus.core_finish_ready), 0);
        repeat (12) next_cycle();
        check("drain1_idle", int'(bus.all_idle), 1);

        // ---- 2: single finish from core 3 (rr_ptr 0 -> 4) ----
        bus.core_finish_valid = 10'b00_0000_1000;
        n = cyc;
        expect_finish(3, n + 2);
        next_cycle();
        bus.core_finish_valid = '0;
        check("single_ready3_n1", int'(bus.core_finish_ready[3]), 0);
        check("single_count_n1", int'(bus.pending_count), 1);
        check("single_idle_n1", int'(bus.all_idle), 0);
        next_cycle();
        check("single_ready3_n2", int'(bus.core_finish_ready[3]), 1);
        check("single_count_n2", int'(bus.pending_count), 0);
        repeat (4) next_cycle();

        // ---- 4: hold with rr_ptr=4: cores 1,4,6,8 -> 4,6,8,1 ----
        bus.core_finish_valid = 10'b01_0101_0010;
        n = cyc;
        next_cycle();
        bus.core_finish_valid = '0;
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_count", int'(bus.pending_count), 4);
            check("hold_ready", int'(bus.core_finish_ready & 10'b01_0101_0010), 0);
            check("hold_idle", int'(bus.all_idle), 0);
            next_cycle();
        end
        bus.hold = 1'b0;
        expect_finish(4, n + 7);
        expect_finish(6, n + 8);
        expect_finish(8, n + 9);
        expect_finish(1, n + 10);
        repeat (8) next_cycle();
        check("hold_drain_idle", int'(bus.all_idle), 1);

        // Reset to bring rr_ptr back to 0.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("rst_b_count", int'(bus.pending_count), 0);
        repeat (2) next_cycle();

        // ---- 3: fairness 0,2,9 then 9,0 ----
        bus.core_finish_valid = 10'b10_0000_0101;
        n = cyc;
        expect_finish(0, n + 2);
        expect_finish(2, n + 3);
        expect_finish(9, n + 4);
        next_cycle();
        bus.core_finish_valid = '0;
        check("fair_count", int'(bus.pending_count), 3);
        repeat (5) next_cycle();
        bus.core_finish_valid = 10'b10_0000_0001;
        n = cyc;
        expect_finish(0, n + 2);
        expect_finish(9, n + 3);
        next_cycle();
        bus.core_finish_valid = '0;
        repeat (6) next_cycle();

        // ---- 5: all cores valid for 30 cycles, rr_ptr=0 ----
        bus.core_finish_valid = '1;
        n = cyc;
        for (int k = 0; k < 38; k++) expect_finish(k % NUM_CORES, n + 2 + k);
        for (int i = 0; i < 30; i++) begin
            if (i > 0) check("full_idle", int'(bus.all_idle), 0);
            check("full_count_le10", int'(bus.pending_count <= NUM_CORES), 1);
            next_cycle();
        end
        bus.core_finish_valid = '0;
        for (int i = 30; i < 40; i++) begin
            check("full_drain_idle", int'(bus.all_idle), 0);
            next_cycle();
        end
        check("full_done_idle", int'(bus.all_idle), 1);
        check("full_done_count", int'(bus.pending_count), 0);
        repeat (3) next_cycle();

        // ---- 6: reset mid-operation with 5 pending ----
        bus.core_finish_valid = 10'b00_0001_1111;
        next_cycle();
        bus.core_finish_valid = '0;
        rst = 1'b1;
        check("midrst_count_before", int'(bus.pending_count), 5);
        next_cycle();
        rst = 1'b0;
        check("midrst_count", int'(bus.pending_count), 0);
        check("midrst_valid", int'(bus.finished_task_valid), 0);
        check("midrst_idle", int'(bus.all_idle), 1);
        check("midrst_ready", int'(bus.core_finish_ready), all_ones);
        repeat (12) next_cycle();
        check("midrst_still_idle", int'(bus.all_idle), 1);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
